// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_e    : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   PORT_CPU   : owner code of port 0 (CPU load/store unit)
//   PORT_LDR   : owner code of port 1 (loader / DMA)
//   WORD_BYTES : bytes per access word
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_LDR   = 1'b1;
  localparam int   WORD_BYTES = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of dmem_arbiter.
//   Requester n (n = 0 CPU, 1 loader):
//     reqn, wen, addrn, wdatan : request side, held stable until ackn
//     ackn, errn, rdatan       : one-cycle completion, error flag, read data
//   Memory side:
//     mem_addr, mem_read, mem_write, mem_wdata : arbiter -> memory
//     mem_rdata                                : memory -> arbiter (combinational)
// Handshake: a requester raises reqn with we/addr/wdata stable and keeps them
// until ackn pulses for one cycle; errn and rdatan are meaningful only while
// ackn is high. A requester that drops reqn early still receives its ack.
// Modports: slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if #(
  parameter int AW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [31:0]   wdata0;
  logic [31:0]   wdata1;
  logic          ack0;
  logic          ack1;
  logic          err0;
  logic          err1;
  logic [31:0]   rdata0;
  logic [31:0]   rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, err0, err1, rdata0, rdata1,
           mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
           mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Two-way request picker.
//   req0_i, req1_i : pending requests
//   ptr_i          : port preferred when both request (round-robin pointer)
//   grant_o        : some port is picked this cycle
//   owner_o        : picked port (PORT_CPU / PORT_LDR)
// Macro DMEM_ARB_FIXED_PRIO_EN: when defined, port 0 always wins a tie and
// ptr_i is ignored; otherwise ties go to the port named by ptr_i.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic grant_o,
  output logic owner_o
);

  assign grant_o = req0_i | req1_i;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  always_comb begin
    owner_o = PORT_CPU;
    if (!req0_i && req1_i) owner_o = PORT_LDR;
  end
`else
  always_comb begin
    owner_o = PORT_CPU;
    if (req0_i && req1_i) owner_o = ptr_i;
    else if (req1_i)      owner_o = PORT_LDR;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port, byte-addressed, big-endian data memory between the
// CPU (port 0) and the loader/DMA (port 1). One aligned 32-bit access per
// grant, answered by a one-cycle ack; misaligned or out-of-range accesses are
// answered with ack+err and never reach the memory.
// Ports:
//   clk     : clock, all state on posedge
//   rst_n   : asynchronous active-low reset
//   bus     : dmem_arbiter_if.slave (both requesters + memory port)
//   state_o : current FSM state, for debug/observation
// Parameters: MEM_BYTES (memory size in bytes), AW (address width).
// Macro DMEM_ARB_FIXED_PRIO_EN selects fixed priority (CPU wins) instead of
// round-robin arbitration.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus,
  output state_e          state_o
);

  localparam logic [AW-1:0] LAST_WORD = AW'(MEM_BYTES - WORD_BYTES);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          bad_q, bad_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;

  logic          grant;
  logic          pick_owner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_bad;

  dmem_arb_pick u_pick (
    .req0_i  (bus.req0),
    .req1_i  (bus.req1),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .owner_o (pick_owner)
  );

  // Request fields of the port that wins in IDLE.
  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (pick_owner == PORT_LDR) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  // Word accesses must be aligned and lie fully inside the memory.
  assign sel_bad = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    bad_d    = bad_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = pick_owner;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          bad_d   = sel_bad;
          // The port just served becomes the less preferred one.
          ptr_d   = ~pick_owner;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bad_q && !we_q) begin
          if (owner_q == PORT_CPU) rdata0_d = bus.mem_rdata;
          else                     rdata1_d = bus.mem_rdata;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= PORT_CPU;
      owner_q  <= PORT_CPU;
      we_q     <= 1'b0;
      bad_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      bad_q    <= bad_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Memory strobes decode directly from the state register, so an
  // asynchronous reset in ACCESS drops mem_write immediately.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = (state_q == ACCESS) && !bad_q && !we_q;
  assign bus.mem_write = (state_q == ACCESS) && !bad_q &&  we_q;

  assign bus.ack0   = (state_q == RESP) && (owner_q == PORT_CPU);
  assign bus.ack1   = (state_q == RESP) && (owner_q == PORT_LDR);
  assign bus.err0   = bus.ack0 && bad_q;
  assign bus.err1   = bus.ack1 && bad_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

  assign state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32)) bus ();
  state_e state;

  dmem_arbiter #(.MEM_BYTES(1024), .AW(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- memory model (comb read, posedge write, big-endian) ----
  logic [7:0] mem [0:1023];

  always_comb begin
    bus.mem_rdata = 32'h0;
    if (bus.mem_addr <= 32'd1020)
      bus.mem_rdata = {mem[bus.mem_addr[9:0]],         mem[bus.mem_addr[9:0] + 10'd1],
                       mem[bus.mem_addr[9:0] + 10'd2], mem[bus.mem_addr[9:0] + 10'd3]};
  end

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr <= 32'd1020) begin
      mem[bus.mem_addr[9:0]]         <= bus.mem_wdata[31:24];
      mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_wdata[23:16];
      mem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_wdata[15:8];
      mem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_wdata[7:0];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_reqs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0  = 1'b0; bus.we1  = 1'b0;
    bus.addr0 = 32'h0; bus.addr1 = 32'h0;
    bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
  endtask

  task automatic pulse_reset();
    clear_reqs();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One request on one port; lat = cycles from request cycle to ack (-1 = none).
  task automatic run_req(input bit port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic err,
                         output logic [31:0] rdata, output int rd_cyc, output int rd_first,
                         output int wr_cyc);
    lat = -1; err = 1'b0; rdata = 32'h0; rd_cyc = 0; rd_first = -1; wr_cyc = 0;
    @(posedge clk); #1;
    if (port == 1'b0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
    for (int c = 0; c < 8 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.mem_read) begin
        rd_cyc++;
        if (rd_first < 0) rd_first = c;
      end
      if (bus.mem_write) wr_cyc++;
      if (port == 1'b0 && bus.ack0) begin
        lat = c; err = bus.err0; rdata = bus.rdata0;
      end
      if (port == 1'b1 && bus.ack1) begin
        lat = c; err = bus.err1; rdata = bus.rdata1;
      end
    end
    @(posedge clk); #1;
    clear_reqs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_cmp++; if ({bus.ack0, bus.ack1, bus.err0, bus.err1} !== 4'b0) begin
      n_err++; $display("FAIL reset_acks: got %b expected 0000", {bus.ack0, bus.ack1, bus.err0, bus.err1});
    end
    n_cmp++; if ({bus.mem_read, bus.mem_write} !== 2'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b expected 00", {bus.mem_read, bus.mem_write});
    end
    n_cmp++; if ({bus.rdata0, bus.rdata1} !== 64'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h expected 0", {bus.rdata0, bus.rdata1});
    end
    n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_mem_bus: got %h expected 0", {bus.mem_addr, bus.mem_wdata});
    end
    n_cmp++; if (state !== IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_read();
    int lat; logic err; logic [31:0] rd; int rc; int rf; int wc;
    run_req(1'b0, 1'b0, 32'h10, 32'h0, lat, err, rd, rc, rf, wc);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL read_lat: got %0d expected 2", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_data: got %h expected deadbeef", rd); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL read_err: got %b expected 0", err); end
    n_cmp++; if (rc !== 1 || rf !== 1) begin
      n_err++; $display("FAIL read_strobe: got %0d cycles first %0d expected 1 cycle at 1", rc, rf);
    end
  endtask

  task automatic test_write_read();
    int lat; logic err; logic [31:0] rd; int rc; int rf; int wc;
    run_req(1'b1, 1'b1, 32'h20, 32'h11223344, lat, err, rd, rc, rf, wc);
    n_cmp++; if (lat !== 2 || err !== 1'b0) begin
      n_err++; $display("FAIL write_ack: got lat %0d err %b expected 2 0", lat, err);
    end
    n_cmp++; if (wc !== 1 || rc !== 0) begin
      n_err++; $display("FAIL write_strobe: got wr %0d rd %0d expected 1 0", wc, rc);
    end
    n_cmp++; if ({mem[32'h20], mem[32'h21], mem[32'h22], mem[32'h23]} !== 32'h11223344) begin
      n_err++; $display("FAIL write_bytes: got %h expected 11223344",
                        {mem[32'h20], mem[32'h21], mem[32'h22], mem[32'h23]});
    end
    run_req(1'b1, 1'b0, 32'h20, 32'h0, lat, err, rd, rc, rf, wc);
    n_cmp++; if (rd !== 32'h11223344 || lat !== 2) begin
      n_err++; $display("FAIL readback: got %h lat %0d expected 11223344 lat 2", rd, lat);
    end
  endtask

  task automatic test_arbitration();
    bit got [0:3];
    bit exp [0:3];
    int n = 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    pulse_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk);
      if (bus.ack0 && bus.ack1) begin
        n_cmp++; n_err++; $display("FAIL arb_double_ack: got both acks expected one");
      end
      if (bus.ack0) begin got[n] = 1'b0; n++; end
      else if (bus.ack1) begin got[n] = 1'b1; n++; end
    end
    @(posedge clk); #1;
    clear_reqs();
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL arb_count: got %0d grants expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (i < n && got[i] !== exp[i]) begin
        n_err++; $display("FAIL arb_grant%0d: got port %0d expected port %0d", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_misaligned_write();
    int lat; logic err; logic [31:0] rd; int rc; int rf; int wc;
    run_req(1'b0, 1'b1, 32'h22, 32'hAABBCCDD, lat, err, rd, rc, rf, wc);
    n_cmp++; if (lat !== 2 || err !== 1'b1) begin
      n_err++; $display("FAIL misalign_ack: got lat %0d err %b expected 2 1", lat, err);
    end
    n_cmp++; if (wc !== 0) begin n_err++; $display("FAIL misalign_strobe: got %0d writes expected 0", wc); end
    n_cmp++; if ({mem[32'h20], mem[32'h21], mem[32'h22], mem[32'h23],
                  mem[32'h24], mem[32'h25], mem[32'h26], mem[32'h27]} !== 64'h11223344_7E7F7C7D) begin
      n_err++; $display("FAIL misalign_mem: got %h expected 112233447e7f7c7d",
                        {mem[32'h20], mem[32'h21], mem[32'h22], mem[32'h23],
                         mem[32'h24], mem[32'h25], mem[32'h26], mem[32'h27]});
    end
  endtask

  task automatic test_range();
    int lat; logic err; logic [31:0] rd; int rc; int rf; int wc;
    run_req(1'b1, 1'b0, 32'd1020, 32'h0, lat, err, rd, rc, rf, wc);
    n_cmp++; if (lat !== 2 || err !== 1'b0 || rd !== 32'hA1B2C3D4) begin
      n_err++; $display("FAIL range_1020: got lat %0d err %b data %h expected 2 0 a1b2c3d4", lat, err, rd);
    end
    run_req(1'b1, 1'b0, 32'd1021, 32'h0, lat, err, rd, rc, rf, wc);
    n_cmp++; if (lat !== 2 || err !== 1'b1 || rc !== 0) begin
      n_err++; $display("FAIL range_1021: got lat %0d err %b rd %0d expected 2 1 0", lat, err, rc);
    end
    n_cmp++; if (rd !== 32'hA1B2C3D4) begin
      n_err++; $display("FAIL range_hold: got %h expected a1b2c3d4", rd);
    end
    run_req(1'b1, 1'b0, 32'd1024, 32'h0, lat, err, rd, rc, rf, wc);
    n_cmp++; if (lat !== 2 || err !== 1'b1 || rc !== 0) begin
      n_err++; $display("FAIL range_1024: got lat %0d err %b rd %0d expected 2 1 0", lat, err, rc);
    end
  endtask

  task automatic test_reset_in_access();
    int lat; logic err; logic [31:0] rd; int rc; int rf; int wc;
    int acks = 0;
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h40; bus.wdata0 = 32'hCAFEF00D;
    @(posedge clk); #2;
    n_cmp++; if (state !== ACCESS || bus.mem_write !== 1'b1) begin
      n_err++; $display("FAIL rst_pre: got state %0d mem_write %b expected %0d 1", state, bus.mem_write, ACCESS);
    end
    #1 rst_n = 1'b0;
    clear_reqs();
    #1;
    n_cmp++; if (bus.mem_write !== 1'b0 || state !== IDLE) begin
      n_err++; $display("FAIL rst_async: got mem_write %b state %0d expected 0 %0d", bus.mem_write, state, IDLE);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL rst_no_ack: got %0d acks expected 0", acks); end
    run_req(1'b0, 1'b0, 32'h10, 32'h0, lat, err, rd, rc, rf, wc);
    n_cmp++; if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rst_recover: got lat %0d err %b data %h expected 2 0 deadbeef", lat, err, rd);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_reqs();
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[32'h10] = 8'hDE; mem[32'h11] = 8'hAD; mem[32'h12] = 8'hBE; mem[32'h13] = 8'hEF;
    mem[1020] = 8'hA1; mem[1021] = 8'hB2; mem[1022] = 8'hC3; mem[1023] = 8'hD4;

    test_reset();
    test_read();
    test_write_read();
    test_arbitration();
    test_misaligned_write();
    test_range();
    test_reset_in_access();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
